// File: rtl/jtframe_ps2_rx_if.sv
// PS/2 receiver bundle: raw pin inputs plus the validated byte output.
// master = the receiver (samples pins, drives byte); slave = pin driver / byte consumer.
interface jtframe_ps2_rx_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] data;
  logic       valid;
  logic       error;
  logic       busy;

  modport master (
    input  ps2_clk,
    input  ps2_data,
    output data,
    output valid,
    output error,
    output busy
  );

  modport slave (
    output ps2_clk,
    output ps2_data,
    input  data,
    input  valid,
    input  error,
    input  busy
  );
endinterface

// File: rtl/jtframe_ps2_rx.sv
// PS/2 device-to-host receiver: synchronizes and glitch-filters the PS/2 pins on
// the system clock and delivers one odd-parity-checked byte per 11-bit frame.
// Optional watchdog enabled by defining JTFRAME_PS2_TIMEOUT_EN.
module jtframe_ps2_rx #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 20000
) (
  input  logic              clk,
  input  logic              rst,
  jtframe_ps2_rx_if.master  bus
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RX   = 1'b1;

  localparam logic [7:0] FLT_MAX = 8'(FILTER_LEN - 1);

  logic       ps2_clk_p0, ps2_clk_p1;
  logic       ps2_data_p0, ps2_data_p1;
  logic [7:0] flt_cnt;
  logic       fclk, fclk_d;
  logic       fall;
  logic [0:0] state;
  logic [3:0] bcnt;
  logic [7:0] shift_sr;
  logic       par_bit;
  logic [7:0] data_r;
  logic       valid_r;
  logic       error_r;

  // Odd parity over data+parity and a high stop bit make a good frame.
  function automatic logic frame_ok(input logic [7:0] d, input logic p, input logic stop);
    frame_ok = (^d ^ p) & stop;
  endfunction

  // Two-flop synchronizers for both asynchronous pins, preset to idle-high.
  always_ff @(posedge clk) begin
    if (rst) begin
      ps2_clk_p0  <= 1'b1;
      ps2_clk_p1  <= 1'b1;
      ps2_data_p0 <= 1'b1;
      ps2_data_p1 <= 1'b1;
    end else begin
      ps2_clk_p0  <= bus.ps2_clk;
      ps2_clk_p1  <= ps2_clk_p0;
      ps2_data_p0 <= bus.ps2_data;
      ps2_data_p1 <= ps2_data_p0;
    end
  end

  // Glitch filter: the filtered clock follows only levels held FILTER_LEN cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      flt_cnt <= 8'd0;
      fclk    <= 1'b1;
      fclk_d  <= 1'b1;
    end else begin
      fclk_d <= fclk;
      if (ps2_clk_p1 != fclk) begin
        if (flt_cnt == FLT_MAX) begin
          fclk    <= ps2_clk_p1;
          flt_cnt <= 8'd0;
        end else begin
          flt_cnt <= flt_cnt + 8'd1;
        end
      end else begin
        flt_cnt <= 8'd0;
      end
    end
  end

  assign fall = fclk_d & ~fclk;

`ifdef JTFRAME_PS2_TIMEOUT_EN
  localparam logic [15:0] WD_MAX = 16'(TIMEOUT - 1);
  logic [15:0] wd_cnt;

  // Watchdog: counts clk cycles since the last sample event while a frame is open.
  always_ff @(posedge clk) begin
    if (rst || fall || state == IDLE) wd_cnt <= 16'd0;
    else                              wd_cnt <= wd_cnt + 16'd1;
  end
`endif

  // Payload shifter and parity capture, LSB first; no reset needed on data.
  always_ff @(posedge clk) begin
    if (fall && state == RX) begin
      if (bcnt <= 4'd8) shift_sr <= {ps2_data_p1, shift_sr[7:1]};
      if (bcnt == 4'd9) par_bit  <= ps2_data_p1;
    end
  end

  // Frame FSM: start bit opens RX, stop bit closes it with a valid or error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      bcnt    <= 4'd0;
      data_r  <= 8'h00;
      valid_r <= 1'b0;
      error_r <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      error_r <= 1'b0;
      if (fall) begin
        case (state)
          IDLE: begin
            if (!ps2_data_p1) begin
              state <= RX;
              bcnt  <= 4'd1;
            end
          end
          RX: begin
            if (bcnt <= 4'd9) begin
              bcnt <= bcnt + 4'd1;
            end else begin
              if (frame_ok(shift_sr, par_bit, ps2_data_p1)) begin
                data_r  <= shift_sr;
                valid_r <= 1'b1;
              end else begin
                error_r <= 1'b1;
              end
              state <= IDLE;
              bcnt  <= 4'd0;
            end
          end
          default: begin
            state <= IDLE;
            bcnt  <= 4'd0;
          end
        endcase
      end
`ifdef JTFRAME_PS2_TIMEOUT_EN
      else if (state == RX && wd_cnt == WD_MAX) begin
        error_r <= 1'b1;
        state   <= IDLE;
        bcnt    <= 4'd0;
      end
`endif
    end
  end

  assign bus.data  = data_r;
  assign bus.valid = valid_r;
  assign bus.error = error_r;
  assign bus.busy  = (state == RX);

endmodule

// File: tb/tb_jtframe_ps2_rx.sv
// Randomized bench for jtframe_ps2_rx: frames are driven at the pins and every
// valid/error pulse is matched against a queue of outcomes computed from the
// frame contents. Watchdog checks run when JTFRAME_PS2_TIMEOUT_EN is defined.
module tb_jtframe_ps2_rx;

  localparam int FILTER_LEN = 8;
  localparam int TIMEOUT    = 1000;
  localparam int H          = 50;   // half bit period in clk cycles

  typedef struct {
    bit         is_err;
    logic [7:0] d;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  jtframe_ps2_rx_if bus();

  jtframe_ps2_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  int         n_chk  = 0;
  int         n_fail = 0;
  int         cyc    = 0;
  int         npulse = 0;
  int         last_pulse_cyc = 0;
  int         last_fall_cyc  = 0;
  logic [7:0] last_data = 8'h00;
  logic       prev_pulse = 1'b0;
  exp_t       expq[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every pulse must match the next queued outcome.
  always @(negedge clk) begin
    exp_t e;
    if (bus.valid || bus.error) begin
      chk("pulse_excl", {31'd0, bus.valid & bus.error}, 0);
      chk("pulse_width", {31'd0, prev_pulse}, 0);
      npulse++;
      last_pulse_cyc = cyc;
      if (expq.size() == 0) begin
        chk("unexpected_pulse", 1, 0);
      end else begin
        e = expq.pop_front();
        chk("pulse_kind_err", {31'd0, bus.error}, {31'd0, e.is_err});
        if (bus.valid) begin
          chk("data", {24'd0, bus.data}, {24'd0, e.d});
          last_data = e.d;
        end else begin
          chk("data_hold", {24'd0, bus.data}, {24'd0, last_data});
        end
      end
    end
    prev_pulse = bus.valid | bus.error;
  end

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic bit good_par(input logic [7:0] b);
    return ~(^b);
  endfunction

  // Drive nedges clock periods of a frame; glitch_bit>=0 puts clock and data
  // glitches inside that bit's period. Queues the outcome for complete frames.
  task automatic send_frame(input logic [7:0] b, input bit par, input bit stop,
                            input int nedges, input int glitch_bit, input bit chk_busy);
    logic [10:0] bits;
    exp_t e;
    bits = {stop, par, b, 1'b0};
    if (nedges == 11) begin
      e.is_err = !(((^b) ^ par) && stop);
      e.d      = b;
      expq.push_back(e);
    end
    for (int i = 0; i < nedges; i++) begin
      bus.ps2_data = bits[i];
      if (i == glitch_bit) begin
        tick(20);
        bus.ps2_clk = 1'b0; tick(3); bus.ps2_clk = 1'b1;
        tick(H - 23);
      end else begin
        tick(H);
      end
      bus.ps2_clk = 1'b0;
      last_fall_cyc = cyc;
      if (i == glitch_bit) begin
        tick(30);
        bus.ps2_data = ~bits[i]; tick(2); bus.ps2_data = bits[i];
        tick(H - 32);
      end else begin
        tick(H);
      end
      bus.ps2_clk = 1'b1;
      if (chk_busy && i == 1) chk("busy_in_frame", {31'd0, bus.busy}, 1);
    end
    if (chk_busy) begin
      tick(20);
      chk("busy_after_frame", {31'd0, bus.busy}, 0);
    end
  endtask

  initial begin
    bit         got;
    int         n0;
    logic [7:0] b;
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(1);
    chk("rst_data",  {24'd0, bus.data}, 0);
    chk("rst_valid", {31'd0, bus.valid}, 0);
    chk("rst_error", {31'd0, bus.error}, 0);
    chk("rst_busy",  {31'd0, bus.busy}, 0);
    tick(10);

    // Clean 0x1C frame with latency measurement on the stop-bit edge.
    send_frame(8'h1C, good_par(8'h1C), 1'b1, 11, -1, 1'b1);
    chk("latency", last_pulse_cyc - last_fall_cyc, FILTER_LEN + 3);
    chk("data_1c", {24'd0, bus.data}, 32'h1C);

    // Bad parity, then bad stop bit followed by a good 0xF0.
    send_frame(8'h1C, ~good_par(8'h1C), 1'b1, 11, -1, 1'b1);
    chk("data_keep", {24'd0, bus.data}, 32'h1C);
    send_frame(8'h75, good_par(8'h75), 1'b0, 11, -1, 1'b1);
    send_frame(8'hF0, good_par(8'hF0), 1'b1, 11, -1, 1'b1);

    // A lone clock pulse with data high in IDLE is ignored.
    bus.ps2_data = 1'b1; tick(H);
    bus.ps2_clk = 1'b0; tick(H); bus.ps2_clk = 1'b1; tick(20);
    chk("idle_high_busy", {31'd0, bus.busy}, 0);

    // Short clock glitch in IDLE, then mid-frame glitches.
    bus.ps2_clk = 1'b0; tick(3); bus.ps2_clk = 1'b1; tick(30);
    chk("idle_glitch_busy", {31'd0, bus.busy}, 0);
    send_frame(8'hE0, good_par(8'hE0), 1'b1, 11, 4, 1'b1);

    // Back-to-back frames.
    n0 = npulse;
    send_frame(8'hE0, good_par(8'hE0), 1'b1, 11, -1, 1'b0);
    send_frame(8'hF0, good_par(8'hF0), 1'b1, 11, -1, 1'b0);
    send_frame(8'h75, good_par(8'h75), 1'b1, 11, -1, 1'b0);
    tick(30);
    chk("b2b_pulses", npulse - n0, 3);

    // Reset mid-frame discards the frame.
    send_frame(8'h29, good_par(8'h29), 1'b1, 6, -1, 1'b0);
    n0 = npulse;
    rst = 1'b1; tick(1); rst = 1'b0;
    last_data = 8'h00;
    tick(30);
    chk("midrst_no_pulse", npulse - n0, 0);
    chk("midrst_data", {24'd0, bus.data}, 0);
    chk("midrst_busy", {31'd0, bus.busy}, 0);
    send_frame(8'h29, good_par(8'h29), 1'b1, 11, -1, 1'b1);

`ifdef JTFRAME_PS2_TIMEOUT_EN
    // Truncated frame: the watchdog fires and the receiver resynchronizes.
    begin
      exp_t e;
      e.is_err = 1'b1;
      e.d      = 8'h00;
      expq.push_back(e);
    end
    n0 = npulse;
    send_frame(8'h29, good_par(8'h29), 1'b1, 5, -1, 1'b0);
    got = 1'b0;
    for (int i = 0; i < 3 * TIMEOUT; i++) begin
      if (npulse != n0) begin
        got = 1'b1;
        break;
      end
      tick(1);
    end
    chk("wd_fired", {31'd0, got}, 1);
    chk("wd_gap", last_pulse_cyc - last_fall_cyc, FILTER_LEN + 3 + TIMEOUT);
    tick(2);
    chk("wd_busy", {31'd0, bus.busy}, 0);
    send_frame(8'h29, good_par(8'h29), 1'b1, 11, -1, 1'b1);
`endif

    // Randomized frames: mostly good, some with bad parity or stop bit.
    for (int k = 0; k < 10; k++) begin
      bit par, stop;
      b    = 8'($urandom);
      par  = ($urandom_range(3) == 0) ? ~good_par(b) : good_par(b);
      stop = ($urandom_range(3) != 0);
      send_frame(b, par, stop, 11, ($urandom_range(3) == 0) ? int'($urandom_range(10)) : -1, 1'b1);
    end

    tick(50);
    chk("pending_outcomes", expq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/jtframe_ps2_rx.md
Name: jtframe_ps2_rx

Overview:
PS/2 device-to-host serial receiver. It turns the raw ps2_clk/ps2_data pins into one validated scan-code byte per frame. It sits directly upstream of the keyboard decoder: data/valid/error plug straight into that decoder's byte input. All logic runs on the system clock; the PS/2 lines are sampled, never used as clocks.

Parameters:
- FILTER_LEN, 8: consecutive clk cycles a synchronized ps2_clk level must hold before the filtered level changes (1..255).
- TIMEOUT, 20000: clk cycles allowed between filtered falling edges inside a frame. Used only when JTFRAME_PS2_TIMEOUT_EN is defined.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: reset, synchronous, active-high.
- ps2_clk, input, 1: raw PS/2 clock pin, asynchronous.
- ps2_data, input, 1: raw PS/2 data pin, asynchronous.
- data, output, 8: last correctly received byte.
- valid, output, 1: one-cycle pulse; data is new.
- error, output, 1: one-cycle pulse; frame rejected.
- busy, output, 1: high while a frame is in progress (state RX).

Behaviour:
- Reset values: data=8'h00, valid=0, error=0, busy=0, filtered clock=1, state=IDLE, bit count=0. The synchronizers preset to 1.
- Synchronization: ps2_clk and ps2_data each pass through 2 flip-flops.
- Glitch filter:
  - A counter tracks how long the synchronized clock has differed from the filtered level.
  - When it reaches FILTER_LEN, the filtered level takes the new value and the counter clears.
  - Any return to the filtered level clears the counter.
- Sample event: filtered clock goes 1->0 (compare against its 1-cycle delayed copy). Synchronized ps2_data is sampled in that cycle.
- FSM, IDLE:
  - On a sample event with data=0 (start bit): go to RX, bit count=1, busy=1.
  - On a sample event with data=1: ignored. No error, stay in IDLE.
- FSM, RX:
  - Bit counts 1..8: shift data in, LSB first.
  - Bit count 9: capture parity.
  - Bit count 10 (stop bit): evaluate the frame and return to IDLE with busy=0.
- Frame check:
  - Good frame: XOR of the 8 data bits and the parity bit =1 (odd parity), and stop bit =1.
  - Good frame: data register updates and valid=1 in the cycle after the stop-bit sample event.
  - Bad frame: error=1 in that same cycle, data unchanged.
- Pulse rules: valid and error are never high together, and never high for more than 1 cycle.
- Latency: from the stop-bit falling edge at the pin to the valid pulse is 2 (sync) + FILTER_LEN + 1 clk cycles.
- Back-to-back frames need no idle gap beyond the PS/2 protocol itself. A start bit sampled on the first edge after IDLE is accepted.
- Reset mid-frame: the frame is discarded and there is no valid or error pulse. The next frame is received normally once its start bit arrives.
- Data lines are only looked at on sample events; ps2_data glitches between edges have no effect.

Optional Feature:
JTFRAME_PS2_TIMEOUT_EN
- Defined:
  - A 16-bit watchdog counter clears on every sample event and in IDLE, and increments in RX.
  - When it reaches TIMEOUT-1 while in RX: error=1 for one cycle, go to IDLE, busy=0, bit count=0.
  - This resynchronizes after a lost edge or a hot-plug.
- Undefined: there is no watchdog counter, and RX waits indefinitely for the remaining edges.

Test Plan:
- Clean frame for 0x1C (start 0, bits 0,0,1,1,1,0,0,0, parity 0, stop 1), 40 us bit period -> exactly one valid pulse, data=8'h1C, error never high, busy falls with valid.
- Same frame with parity bit 1 -> one error pulse, no valid, data keeps its previous value (8'h1C or 8'h00 after reset).
- Frame 0x75 with stop bit 0 -> one error pulse, data unchanged. A following good 0xF0 frame -> valid, data=8'hF0.
- 3-cycle low glitch on ps2_clk in IDLE and mid-frame (FILTER_LEN=8) -> no sample event. Byte 0xE0 is still received correctly.
- Back-to-back frames 0xE0, 0xF0, 0x75 -> three valid pulses, data sequence E0, F0, 75, no errors.
- With JTFRAME_PS2_TIMEOUT_EN and TIMEOUT=1000: stop after 5 edges -> error pulse 1000 cycles after the last edge, busy=0. A following full 0x29 frame -> valid, data=8'h29. rst asserted for 1 cycle mid-frame -> no pulse; the next 0x29 frame is received.
